// File: rtl/dff_pkg.sv
// Shared defaults and the count-width helper for the dff_pipe register pipeline.
package dff_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RST_VAL = '0;

  // Bits needed to hold any occupancy from 0 up to and including depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: a data register plus its valid flag, with optional advance enable.
module dff_stage #(
  parameter int               WIDTH   = 8,
  parameter int               USE_EN  = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic adv;

  assign adv = (USE_EN != 0) ? en : 1'b1;

  // Clear only kills the valid flag; the data register keeps following adv.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= RST_VAL;
      q_valid <= 1'b0;
    end else begin
      if (adv) begin
        q <= d;
      end
      if (clr) begin
        q_valid <= 1'b0;
      end else if (adv) begin
        q_valid <= d_valid;
      end
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// Fixed-latency register pipeline with valid tracking, flush and an occupancy counter.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter int               DEPTH   = DEFAULT_DEPTH,
  parameter int               USE_EN  = 0,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEFAULT_RST_VAL)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [WIDTH-1:0]                d,
  input  logic                            d_valid,
  input  logic                            flush,
  output logic [WIDTH-1:0]                q,
  output logic                            q_valid,
  output logic [count_width(DEPTH)-1:0]   count
);

  localparam int CW = count_width(DEPTH);

  logic             adv;
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic             stage_v [DEPTH];

  assign adv = (USE_EN != 0) ? en : 1'b1;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] in_d;
    logic             in_v;

    if (i == 0) begin : g_head
      assign in_d = d;
      assign in_v = d_valid;
    end else begin : g_body
      assign in_d = stage_d[i-1];
      assign in_v = stage_v[i-1];
    end

    dff_stage #(
      .WIDTH   (WIDTH),
      .USE_EN  (USE_EN),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .clr     (flush),
      .d       (in_d),
      .d_valid (in_v),
      .q       (stage_d[i]),
      .q_valid (stage_v[i])
    );
  end

  assign q       = stage_d[DEPTH-1];
  assign q_valid = stage_v[DEPTH-1];

  // Modular CW-bit arithmetic keeps the full-and-retiring case exact even when DEPTH = 2**CW - 1.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else if (adv) begin
      count <= count + CW'(d_valid) - CW'(q_valid);
    end
  end

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench: several dff_pipe configurations share stimulus and are checked against a queue model.
module tb_dff_pipe;

  localparam int NI = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        d_valid = 1'b0;
  logic [31:0] d = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_all   [NI];
  logic        qv_all  [NI];
  logic [7:0]  cnt_all [NI];

  logic [31:0] md [NI][$];
  bit          mv [NI][$];

  always #5 clk = ~clk;

  logic [7:0]  q0, q1;
  logic        qv0, qv1, qv2, qv3, qv4, qv5;
  logic [2:0]  cnt0, cnt1, cnt4, cnt5;
  logic [0:0]  q2, q5, cnt2;
  logic [31:0] q3, q4;
  logic [1:0]  cnt3;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .USE_EN(0), .RST_VAL(8'h00)) u_k0 (
    .clk(clk), .rst(rst), .en(en), .d(d[7:0]), .d_valid(d_valid), .flush(flush),
    .q(q0), .q_valid(qv0), .count(cnt0));
  dff_pipe #(.WIDTH(8), .DEPTH(4), .USE_EN(1), .RST_VAL(8'h5A)) u_k1 (
    .clk(clk), .rst(rst), .en(en), .d(d[7:0]), .d_valid(d_valid), .flush(flush),
    .q(q1), .q_valid(qv1), .count(cnt1));
  dff_pipe #(.WIDTH(1), .DEPTH(1), .USE_EN(1), .RST_VAL(1'b0)) u_k2 (
    .clk(clk), .rst(rst), .en(en), .d(d[0:0]), .d_valid(d_valid), .flush(flush),
    .q(q2), .q_valid(qv2), .count(cnt2));
  dff_pipe #(.WIDTH(32), .DEPTH(2), .USE_EN(1), .RST_VAL(32'hDEADBEEF)) u_k3 (
    .clk(clk), .rst(rst), .en(en), .d(d), .d_valid(d_valid), .flush(flush),
    .q(q3), .q_valid(qv3), .count(cnt3));
  dff_pipe #(.WIDTH(32), .DEPTH(7), .USE_EN(0), .RST_VAL(32'h0)) u_k4 (
    .clk(clk), .rst(rst), .en(en), .d(d), .d_valid(d_valid), .flush(flush),
    .q(q4), .q_valid(qv4), .count(cnt4));
  dff_pipe #(.WIDTH(1), .DEPTH(7), .USE_EN(1), .RST_VAL(1'b1)) u_k5 (
    .clk(clk), .rst(rst), .en(en), .d(d[0:0]), .d_valid(d_valid), .flush(flush),
    .q(q5), .q_valid(qv5), .count(cnt5));

  assign q_all[0] = 32'(q0);  assign qv_all[0] = qv0;  assign cnt_all[0] = 8'(cnt0);
  assign q_all[1] = 32'(q1);  assign qv_all[1] = qv1;  assign cnt_all[1] = 8'(cnt1);
  assign q_all[2] = 32'(q2);  assign qv_all[2] = qv2;  assign cnt_all[2] = 8'(cnt2);
  assign q_all[3] = q3;       assign qv_all[3] = qv3;  assign cnt_all[3] = 8'(cnt3);
  assign q_all[4] = q4;       assign qv_all[4] = qv4;  assign cnt_all[4] = 8'(cnt4);
  assign q_all[5] = 32'(q5);  assign qv_all[5] = qv5;  assign cnt_all[5] = 8'(cnt5);

  function automatic int cfg_depth(input int k);
    case (k)
      2: return 1;
      3: return 2;
      4, 5: return 7;
      default: return 4;
    endcase
  endfunction

  function automatic bit cfg_use_en(input int k);
    return (k == 0 || k == 4) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [31:0] cfg_mask(input int k);
    case (k)
      0, 1: return 32'hFF;
      2, 5: return 32'h1;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] cfg_rst_val(input int k);
    case (k)
      1: return 32'h5A;
      3: return 32'hDEADBEEF;
      5: return 32'h1;
      default: return 32'h0;
    endcase
  endfunction

  // The model is a history of the last DEPTH accepted items; q is the oldest one.
  task automatic model_reset(input int k);
    md[k].delete();
    mv[k].delete();
    for (int i = 0; i < cfg_depth(k); i++) begin
      md[k].push_back(cfg_rst_val(k));
      mv[k].push_back(1'b0);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        model_reset(k);
      end else begin
        if (!cfg_use_en(k) || en) begin
          md[k].push_front(d & cfg_mask(k));
          mv[k].push_front(d_valid);
          void'(md[k].pop_back());
          void'(mv[k].pop_back());
        end
        if (flush) begin
          for (int i = 0; i < mv[k].size(); i++) mv[k][i] = 1'b0;
        end
      end
    end
  endtask

  function automatic int model_count(input int k);
    int n = 0;
    for (int i = 0; i < mv[k].size(); i++) n += int'(mv[k][i]);
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    for (int k = 0; k < NI; k++) begin
      checkOutput($sformatf("model k%0d q", k), q_all[k], md[k][md[k].size()-1]);
      checkOutput($sformatf("model k%0d q_valid", k), 32'(qv_all[k]), 32'(mv[k][mv[k].size()-1]));
      checkOutput($sformatf("model k%0d count", k), 32'(cnt_all[k]), 32'(model_count(k)));
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic f,
                               input logic dv, input logic [31:0] dd);
    rst = r; en = e; flush = f; d_valid = dv; d = dd;
    @(posedge clk);
    model_step();
    #1;
    check_models();
  endtask

  typedef struct {
    logic       rst;
    logic       flush;
    logic       dv;
    logic [7:0] d;
    logic [7:0] q;
    logic       qv;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs [20];
  logic [31:0] sent [$];

  initial begin
    for (int k = 0; k < NI; k++) model_reset(k);

    // Expected values for the DEPTH=4, USE_EN=0 instance, worked out by hand.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'hA1, 8'h00, 1'b0, 3'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'hB2, 8'h00, 1'b0, 3'd2};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'hC3, 8'h00, 1'b0, 3'd3};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'hD4, 8'hA1, 1'b1, 3'd4};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'hE5, 8'hB2, 1'b1, 3'd4};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b1, 3'd3};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hD4, 1'b1, 3'd2};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h66, 8'h00, 1'b0, 3'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h21, 8'h00, 1'b0, 3'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h32, 8'h00, 1'b0, 3'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h43, 8'h00, 1'b0, 3'd3};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h54, 8'h21, 1'b1, 3'd4};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 8'h77, 8'h32, 1'b0, 3'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h43, 1'b0, 3'd0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h54, 1'b0, 3'd0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h77, 1'b0, 3'd0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 8'h99, 8'h00, 1'b0, 3'd1};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 8'h88, 8'h00, 1'b0, 3'd2};
    vecs[19] = '{1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0};

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].rst, 1'b1, vecs[i].flush, vecs[i].dv, 32'(vecs[i].d));
      checkOutput($sformatf("vec%0d q", i), 32'(q0), 32'(vecs[i].q));
      checkOutput($sformatf("vec%0d q_valid", i), 32'(qv0), 32'(vecs[i].qv));
      checkOutput($sformatf("vec%0d count", i), 32'(cnt0), 32'(vecs[i].cnt));
    end

    // Enable stall on the USE_EN=1 instance, whose reset value is 0x5A.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    checkOutput("stall rst q", 32'(q1), 32'h5A);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h55);
    checkOutput("stall load count", 32'(cnt1), 32'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, $urandom);
      checkOutput($sformatf("stall%0d q", i), 32'(q1), 32'h5A);
      checkOutput($sformatf("stall%0d q_valid", i), 32'(qv1), 32'h0);
      checkOutput($sformatf("stall%0d count", i), 32'(cnt1), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("resume%0d q", i), 32'(q1), (i == 2) ? 32'h55 : 32'h5A);
      checkOutput($sformatf("resume%0d q_valid", i), 32'(qv1), (i == 2) ? 32'h1 : 32'h0);
      checkOutput($sformatf("resume%0d count", i), 32'(cnt1), 32'd1);
    end

    // Continuous full-rate stream against a scoreboard of sent bytes.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int n = 1; n <= 20; n++) begin
      sent.push_back($urandom & 32'hFF);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, sent[n-1]);
      checkOutput($sformatf("stream%0d count", n), 32'(cnt0), (n >= 4) ? 32'd4 : 32'(n));
      if (n >= 4) checkOutput($sformatf("stream%0d q", n), 32'(q0), sent[n-4]);
    end

    // Random sweep across all configurations, checked entirely by the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 11) == 0), $urandom_range(0, 3) != 0, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, sets the data width in bits; legal values are 1 or more.
REQ-002 Parameter DEPTH, default 4, sets the number of register stages and the latency; legal values are 1 or more.
REQ-003 Parameter USE_EN, default 0; when 0 the en port is ignored and the pipe advances every cycle.
REQ-004 Parameter RST_VAL, default 0 (WIDTH bits), is the data value loaded into every stage by reset.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 en  input  1  advance enable; used only when USE_EN=1.
REQ-008 d  input  WIDTH  data into stage 0.
REQ-009 d_valid  input  1  marks d as a valid item.
REQ-010 flush  input  1  synchronous invalidate of all stages.
REQ-011 q  output  WIDTH  data of stage DEPTH-1.
REQ-012 q_valid  output  1  valid flag of stage DEPTH-1.
REQ-013 count  output  CW=$clog2(DEPTH+1)  number of valid items held in the pipe.

Function
REQ-014 Define adv = 1 when USE_EN=0; otherwise adv = en.
REQ-015 On a clock edge with adv=1, rst=0 and flush=0: stage 0 loads {d, d_valid}, and stage i loads stage i-1 for i = 1..DEPTH-1.
REQ-016 On a clock edge with adv=0, rst=0 and flush=0, every stage data and valid bit holds its value.
REQ-017 Stage data is captured whatever the value of d_valid; q is meaningful only while q_valid=1.
REQ-018 q and q_valid are taken directly from registers of stage DEPTH-1, with no combinational path from any input.
REQ-019 Latency: an item presented with adv=1 at edge N appears on q after the DEPTH-th advancing edge, counting edge N as the first; with USE_EN=0 this is edge N+DEPTH-1.
REQ-020 When flush=1 (and rst=0), all valid bits clear at the edge regardless of adv, and the item on d is dropped.
REQ-021 When flush=1 (and rst=0), data registers follow the rules of REQ-015 and REQ-016.
REQ-022 count is registered and equals the population count of the valid bits after every edge.
REQ-023 count update when adv=1: count_next = count + d_valid - q_valid.
REQ-024 count update when adv=0: count holds.
REQ-025 count update when flush=1: count_next = 0.
REQ-026 At full (count=DEPTH) with adv=1 and d_valid=1, the output item retires and count remains DEPTH; no overflow is possible.
REQ-027 At empty (count=0) with adv=1 and d_valid=0, count remains 0; no underflow is possible.
REQ-028 Priority order: rst, then flush, then adv, then hold.

Reset
REQ-029 On an edge with rst=1: every stage data = RST_VAL, every valid bit = 0, q = RST_VAL, q_valid = 0 and count = 0, regardless of en, flush and d_valid.
REQ-030 Reset asserted mid-stream discards all in-flight items; the first item accepted after rst falls obeys REQ-019.

Structure
REQ-031 Package dff_pkg holds the count-width helper function and the default WIDTH, DEPTH and RST_VAL constants.
REQ-032 One sub-module, dff_stage (parameters WIDTH, USE_EN, RST_VAL; ports clk, rst, en, clr, d, d_valid, q, q_valid), is instantiated DEPTH times in a generate loop.
REQ-033 The count logic resides in dff_pipe.

Verification
REQ-034 USE_EN=0, DEPTH=4: rst for 1 cycle, then d = 0xA1, 0xB2, 0xC3, 0xD4 with d_valid=1 on consecutive edges -> q = 0xA1 with q_valid=1 after the 4th edge, then B2, C3, D4 in order; count reaches 4.
REQ-035 USE_EN=1: load 0x55 with en=1, then hold en=0 for 5 cycles -> q, q_valid and count unchanged; resuming en=1 delivers 0x55 after the remaining advances.
REQ-036 Fill to count=4, then assert flush=1 with d_valid=1 and d=0x77 -> after the edge, q_valid=0, count=0, and 0x77 never appears valid.
REQ-037 Full stream: keep d_valid=1 and adv=1 for 20 cycles -> count stays 4 from cycle 4 onward and q is d delayed by 4 cycles, matched against a scoreboard.
REQ-038 rst=1 concurrent with flush=1, en=1 and d_valid=1 -> q = RST_VAL, q_valid=0, count=0.
REQ-039 Sweep DEPTH = 1, 2, 7 and WIDTH = 1, 32 with random d, d_valid, en and flush -> zero mismatches against a reference queue model; report error and correct counts at the end.
